// File: rtl/coh_msg_sched.sv
// coh_msg_sched: schedules coherence messages from cache_num cache controllers
// onto one shared snoop/directory channel.
//   - Round-robin grant (scan upward from rr_ptr, wrap), combinational one-hot
//     msg_gnt while IDLE; the granted message is captured into a registered
//     output stage with valid/ready handshake.
//   - Broadcast-type messages hold off further grants until every non-source
//     cache has pulsed snoop_ack, or until ACK_TIMEOUT cycles elapse
//     (ack_timeout pulses once on abort).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   msg_req  [N]        per-cache request, message held stable until granted
//   msg_gnt  [N]        one-hot accept pulse (message sampled on that edge)
//   msg      [N*MSG_W]  packed messages, cache i at [i*MSG_W +: MSG_W]
//   msg_out_valid/ready registered output handshake
//   msg_out  [MSG_W]    registered message {type, src_id, dst_id, addr}
//   snoop_ack[N]        per-cache ack pulse for the outstanding broadcast
//   bcast_busy          high while waiting for broadcast acks
//   ack_timeout         one-cycle pulse when a broadcast wait is aborted
//
// state    | meaning
// IDLE     | arbitrating; grant issued combinationally when any request is up
// SEND     | msg_out_valid held until the downstream consumer accepts
// WAIT_ACK | broadcast outstanding; collecting snoop acks, timeout counting
module coh_msg_sched #(
  parameter int         cache_num   = 4,
  parameter int         addr_width  = 32,
  parameter logic [3:0] BCAST_TYPE  = 4'h3,
  parameter int         ACK_TIMEOUT = 256,
  localparam int        ID_W        = $clog2(cache_num),
  localparam int        MSG_W       = 4 + 2*ID_W + addr_width
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [cache_num-1:0]       msg_req,
  output logic [cache_num-1:0]       msg_gnt,
  input  logic [cache_num*MSG_W-1:0] msg,
  output logic                       msg_out_valid,
  input  logic                       msg_out_ready,
  output logic [MSG_W-1:0]           msg_out,
  input  logic [cache_num-1:0]       snoop_ack,
  output logic                       bcast_busy,
  output logic                       ack_timeout
);

  localparam int              CNT_W   = $clog2(ACK_TIMEOUT);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(cache_num - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [MSG_W-1:0]     r_msg_out;
  logic                 r_msg_out_valid;
  logic                 r_bcast_busy;
  logic                 r_ack_timeout;
  logic [cache_num-1:0] r_ack_pend;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_found;
  logic [ID_W-1:0]      w_idx;
  logic [cache_num-1:0] w_gnt;
  logic [MSG_W-1:0]     w_msg_arr [cache_num];
  logic [3:0]           w_type;
  logic [ID_W-1:0]      w_src;
  logic [cache_num-1:0] w_src_onehot;
  logic [cache_num-1:0] w_nxt_pend;

  always_comb begin
    for (int k = 0; k < cache_num; k++) begin
      w_msg_arr[k] = msg[k*MSG_W +: MSG_W];
    end
  end

  // Rotating priority scan: first requester at or above rr_ptr, wrapping.
  always_comb begin
    int              j;
    logic [ID_W-1:0] j_idx;
    w_found = 1'b0;
    w_idx   = '0;
    j       = 0;
    j_idx   = '0;
    for (int k = 0; k < cache_num; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= cache_num) j = j - cache_num;
      j_idx = ID_W'(j);
      if (!w_found && msg_req[j_idx]) begin
        w_found = 1'b1;
        w_idx   = j_idx;
      end
    end
  end

  // Grant is combinational; gated by rst_n so nothing is granted in reset.
  always_comb begin
    w_gnt = '0;
    if (rst_n && (r_state == IDLE) && w_found) w_gnt[w_idx] = 1'b1;
  end

  assign w_type = r_msg_out[MSG_W-1 -: 4];
  assign w_src  = r_msg_out[addr_width+ID_W +: ID_W];

  always_comb begin
    w_src_onehot        = '0;
    w_src_onehot[w_src] = 1'b1;
  end

  assign w_nxt_pend = r_ack_pend & ~snoop_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_rr_ptr        <= '0;
      r_msg_out       <= '0;
      r_msg_out_valid <= 1'b0;
      r_bcast_busy    <= 1'b0;
      r_ack_timeout   <= 1'b0;
      r_ack_pend      <= '0;
      r_cnt           <= '0;
    end else begin
      r_ack_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_msg_out       <= w_msg_arr[w_idx];
            r_msg_out_valid <= 1'b1;
            r_rr_ptr        <= (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;
            r_state         <= SEND;
          end
        end
        SEND: begin
          if (msg_out_ready) begin
            r_msg_out_valid <= 1'b0;
            if (w_type == BCAST_TYPE) begin
              r_ack_pend   <= ~w_src_onehot;
              r_cnt        <= '0;
              r_bcast_busy <= 1'b1;
              r_state      <= WAIT_ACK;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        WAIT_ACK: begin
          r_ack_pend <= w_nxt_pend;
          // Completion is checked first so it wins over a same-cycle timeout.
          if (w_nxt_pend == '0) begin
            r_bcast_busy <= 1'b0;
            r_state      <= IDLE;
          end else if (r_cnt == CNT_MAX) begin
            r_ack_timeout <= 1'b1;
            r_ack_pend    <= '0;
            r_bcast_busy  <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign msg_gnt       = w_gnt;
  assign msg_out       = r_msg_out;
  assign msg_out_valid = r_msg_out_valid;
  assign bcast_busy    = r_bcast_busy;
  assign ack_timeout   = r_ack_timeout;

endmodule

// File: tb/tb_coh_msg_sched.sv
module tb_coh_msg_sched;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int MSG_W = 40;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       msg_req;
  logic [N-1:0]       msg_gnt;
  logic [N*MSG_W-1:0] msg;
  logic               msg_out_valid;
  logic               msg_out_ready;
  logic [MSG_W-1:0]   msg_out;
  logic [N-1:0]       snoop_ack;
  logic               bcast_busy;
  logic               ack_timeout;

  logic [MSG_W-1:0]   m [N];

  int checks;
  int failures;

  coh_msg_sched #(
    .cache_num  (N),
    .addr_width (AW),
    .BCAST_TYPE (4'h3),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg_req      (msg_req),
    .msg_gnt      (msg_gnt),
    .msg          (msg),
    .msg_out_valid(msg_out_valid),
    .msg_out_ready(msg_out_ready),
    .msg_out      (msg_out),
    .snoop_ack    (snoop_ack),
    .bcast_busy   (bcast_busy),
    .ack_timeout  (ack_timeout)
  );

  assign msg = {m[3], m[2], m[1], m[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] ack;
    logic [3:0] gnt;
    logic       vld;
    int         oidx;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [1:0] s,
                                          input logic [1:0] d, input logic [31:0] a);
    return {t, s, d, a};
  endfunction

  function automatic vec_t v(input logic [3:0] req, input logic rdy, input logic [3:0] ack,
                             input logic [3:0] gnt, input logic vld, input int oidx);
    vec_t r;
    r.req = req; r.rdy = rdy; r.ack = ack; r.gnt = gnt; r.vld = vld; r.oidx = oidx;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Apply inputs just after the rising edge, then sample at the falling edge.
  task automatic step(input logic [3:0] req, input logic rdy, input logic [3:0] ack);
    @(posedge clk);
    #1;
    msg_req       = req;
    msg_out_ready = rdy;
    snoop_ack     = ack;
    @(negedge clk);
  endtask

  logic [MSG_W-1:0] uni [N];
  logic [MSG_W-1:0] bc1;
  logic             saw_to;

  initial begin
    checks   = 0;
    failures = 0;
    uni[0] = mk(4'h1, 2'd0, 2'd1, 32'h0000_0A00);
    uni[1] = mk(4'h1, 2'd1, 2'd2, 32'h0000_0B00);
    uni[2] = mk(4'h1, 2'd2, 2'd3, 32'h0000_1000);
    uni[3] = mk(4'h1, 2'd3, 2'd0, 32'h0000_0C00);
    bc1    = mk(4'h3, 2'd1, 2'd0, 32'hBEEF_0000);
    for (int i = 0; i < N; i++) m[i] = uni[i];

    rst_n = 1'b0;
    msg_req = '0; msg_out_ready = 1'b1; snoop_ack = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", msg_out_valid, 0);
    chk("reset_out",   msg_out, 0);
    chk("reset_busy",  bcast_busy, 0);
    rst_n = 1'b1;

    // reset state, fairness, unicast, backpressure
    tbl.push_back(v(4'b0000,1,4'b0000, 4'b0000,0,0));
    for (int r = 0; r < 6; r++) begin
      tbl.push_back(v(4'b1111,1,4'b0000, 4'(1 << (r % 4)),0,0));
      tbl.push_back(v(4'b1111,1,4'b0000, 4'b0000,1,r % 4));
    end
    tbl.push_back(v(4'b0000,1,4'b1111, 4'b0000,0,0));
    tbl.push_back(v(4'b0100,1,4'b0000, 4'b0100,0,0));
    tbl.push_back(v(4'b0000,1,4'b0000, 4'b0000,1,2));
    tbl.push_back(v(4'b0000,1,4'b1111, 4'b0000,0,0));
    tbl.push_back(v(4'b1011,0,4'b0000, 4'b1000,0,0));
    for (int r = 0; r < 5; r++) tbl.push_back(v(4'b0011,0,4'b0000, 4'b0000,1,3));
    tbl.push_back(v(4'b0011,1,4'b0000, 4'b0000,1,3));
    tbl.push_back(v(4'b0011,1,4'b0000, 4'b0001,0,0));
    tbl.push_back(v(4'b0010,1,4'b0000, 4'b0000,1,0));
    tbl.push_back(v(4'b0010,1,4'b0000, 4'b0010,0,0));
    tbl.push_back(v(4'b0000,1,4'b0000, 4'b0000,1,1));
    tbl.push_back(v(4'b0000,1,4'b0000, 4'b0000,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].rdy, tbl[i].ack);
      chk($sformatf("row%0d_gnt", i), msg_gnt, tbl[i].gnt);
      chk($sformatf("row%0d_vld", i), msg_out_valid, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("row%0d_out", i), msg_out, uni[tbl[i].oidx]);
      chk($sformatf("row%0d_busy", i), bcast_busy, 0);
      chk($sformatf("row%0d_to", i), ack_timeout, 0);
    end

    // broadcast from cache 1 (rr_ptr=2): acks 0, then 1 (stray), then 2+3
    m[1] = bc1;
    step(4'b0010,1,4'b0000);
    chk("bc_gnt", msg_gnt, 4'b0010);
    step(4'b0000,1,4'b0000);
    chk("bc_vld", msg_out_valid, 1);
    chk("bc_out", msg_out, bc1);
    step(4'b0001,1,4'b0001);
    chk("bc_busy_a0", bcast_busy, 1);
    chk("bc_gnt_a0", msg_gnt, 0);
    chk("bc_vld_a0", msg_out_valid, 0);
    step(4'b0001,1,4'b0010);
    chk("bc_busy_a1", bcast_busy, 1);
    chk("bc_gnt_a1", msg_gnt, 0);
    step(4'b0001,1,4'b1100);
    chk("bc_busy_a23", bcast_busy, 1);
    chk("bc_gnt_a23", msg_gnt, 0);
    step(4'b0001,1,4'b0000);
    chk("bc_busy_done", bcast_busy, 0);
    chk("bc_to_done", ack_timeout, 0);
    chk("bc_gnt_after", msg_gnt, 4'b0001);
    step(4'b0000,1,4'b0000);
    chk("bc_next_out", msg_out, uni[0]);
    step(4'b0000,1,4'b0000);
    chk("bc_idle_vld", msg_out_valid, 0);

    // timeout: cache 1 broadcasts, caches 0 and 2 ack, cache 3 never does
    step(4'b0010,1,4'b0000);
    chk("to_gnt", msg_gnt, 4'b0010);
    step(4'b0001,1,4'b0000);
    chk("to_out", msg_out, bc1);
    for (int c = 0; c < 8; c++) begin
      step(4'b0001,1,(c == 0) ? 4'b0101 : 4'b0000);
      chk($sformatf("to_w%0d_busy", c), bcast_busy, 1);
      chk($sformatf("to_w%0d_to", c), ack_timeout, 0);
      chk($sformatf("to_w%0d_gnt", c), msg_gnt, 0);
    end
    step(4'b0001,1,4'b0000);
    chk("to_pulse", ack_timeout, 1);
    chk("to_busy_drop", bcast_busy, 0);
    chk("to_next_gnt", msg_gnt, 4'b0001);
    step(4'b0000,1,4'b0000);
    chk("to_pulse_end", ack_timeout, 0);
    chk("to_next_out", msg_out, uni[0]);

    // completion in the final timeout cycle wins, no pulse
    step(4'b0010,1,4'b0000);
    chk("ct_gnt", msg_gnt, 4'b0010);
    step(4'b0000,1,4'b0000);
    chk("ct_out", msg_out, bc1);
    for (int c = 0; c < 8; c++) begin
      step(4'b0000,1,(c == 7) ? 4'b1101 : 4'b0000);
      chk($sformatf("ct_w%0d_busy", c), bcast_busy, 1);
    end
    step(4'b0000,1,4'b0000);
    chk("ct_busy_drop", bcast_busy, 0);
    chk("ct_no_pulse", ack_timeout, 0);
    step(4'b0000,1,4'b0000);
    chk("ct_no_pulse2", ack_timeout, 0);

    // async reset during WAIT_ACK
    step(4'b0010,1,4'b0000);
    chk("rs_gnt", msg_gnt, 4'b0010);
    step(4'b0000,1,4'b0000);
    step(4'b0000,1,4'b0000);
    chk("rs_busy_pre", bcast_busy, 1);
    #2;
    rst_n   = 1'b0;
    msg_req = 4'b1111;
    #1;
    chk("rs_busy", bcast_busy, 0);
    chk("rs_vld", msg_out_valid, 0);
    chk("rs_out", msg_out, 0);
    chk("rs_gnt0", msg_gnt, 0);
    chk("rs_to", ack_timeout, 0);
    @(posedge clk);
    #1;
    msg_req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111,1,4'b0000);
    chk("rs_first_gnt", msg_gnt, 4'b0001);
    saw_to = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(4'b0000,1,4'b0000);
      if (ack_timeout) saw_to = 1'b1;
    end
    chk("rs_no_pulse", saw_to, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
